fir_mac_seq: RTL and testbench
==============================

# fir_mac_seq

Sequencer for the FIR filter's single shared multiply-accumulate datapath. It accepts one 16-bit sample per handshake and stores it in a circular delay line. It then steps through all taps one per clock, reading coefficients from an external ROM. Finally it scales the accumulator by 2^-10, saturates the result to signed 16 bits and presents it with a one-cycle valid pulse. It sits between the sample source (demodulator front end) and the downstream filtered-sample consumer.

## Interface
Parameters:
- NTAPS, 16, number of taps; power of two, at least 2.
- DW, 16, sample and coefficient width (signed).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of delay line and sequencer.
- smpl_in  in  DW  signed input sample.
- smpl_vld  in  1  smpl_in is valid.
- smpl_rdy  out  1  block can accept a sample.
- coeff_addr  out  log2(NTAPS)  tap index to the coefficient ROM.
- coeff  in  DW  signed coefficient; combinational ROM, valid in the same cycle as coeff_addr.
- smpl_out  out  DW  saturated filtered sample.
- out_vld  out  1  one-cycle pulse; smpl_out is new.

## Operation
- Delay line: NTAPS x DW registers, write pointer wptr (log2(NTAPS) bits, wraps modulo NTAPS).
- Handshake: a sample is accepted when smpl_vld && smpl_rdy. smpl_rdy = (state == IDLE) && !flush.
- On accept:
  - buf[wptr] <= smpl_in; wptr <= wptr+1.
  - acc <= 0; tap <= 0; state -> MAC.
- MAC state, each cycle k = 0..NTAPS-1:
  - coeff_addr = tap = k.
  - Operand = buf[(wptr-1-k) mod NTAPS], i.e. the newest sample pairs with coeff[0].
  - acc <= acc + sext(operand*coeff), where the product is a full 2*DW signed product.
  - tap increments. At k = NTAPS-1: smpl_out <= sat(acc_next), out_vld <= 1, state -> IDLE.
- Accumulator width ACCW = 2*DW + log2(NTAPS); it must never overflow internally.
- Scaling and saturation:
  - Nominal result = acc[DW+9:10].
  - If acc[ACCW-1:DW+9] are all equal, output the nominal result.
  - Otherwise output 0x7FFF when acc[ACCW-1]=0, and 0x8000 when acc[ACCW-1]=1.
  - The decision uses the full accumulator, not a truncated window.
- coeff_addr holds its last value (or 0 after reset/flush) outside MAC.
- flush, highest priority, any state:
  - All buf entries <= 0; wptr <= 0; tap <= 0; acc <= 0; state -> IDLE.
  - An in-flight computation is aborted: no out_vld is produced.
  - A smpl_vld in the same cycle is dropped.
- Reset values: state IDLE, buf all 0, wptr 0, tap 0, acc 0, coeff_addr 0, smpl_out 0, out_vld 0. smpl_rdy is 1 once rst_n is deasserted.

## Timing
- Accept in cycle t. MAC occupies cycles t+1 .. t+NTAPS. out_vld is high in cycle t+NTAPS+1 only.
- In cycle t+NTAPS+1 the state is IDLE and smpl_rdy=1. A new sample may be accepted in that same cycle.
- Peak throughput: one sample per NTAPS+1 cycles.
- smpl_vld while smpl_rdy=0 is ignored; the source must hold it.
- smpl_out holds its value until the next out_vld. It is unchanged by flush and reset only by rst_n.
- rst_n asserted mid-MAC clears everything immediately (async). No out_vld follows.

## Structure
- Shared package fir_pkg holds:
  - NTAPS and DW defaults.
  - The ACCW derivation.
  - The state enum {IDLE, MAC}.
  - Saturation constants SAT_POS = 16'h7FFF and SAT_NEG = 16'h8000.
- One sub-module, acc_sat: a combinational ACCW -> DW scale-by-2^-10 and saturate, parameterised on ACCW/DW. It is reused by the decimator.
- Top level holds the FSM, delay line, tap counter and accumulator.

## Test plan
- Impulse: coeff[k] = 100+k, send 0x0400 followed by NTAPS-1 zeros. Required: smpl_out sequence 100, 101, ..., 100+NTAPS-1, each out_vld exactly NTAPS+1 cycles after its accept.
- Positive saturation: all coeff 0x7FFF, all samples 0x7FFF. Required: smpl_out = 0x7FFF once the line is full. Drive samples 0x0010 from a fresh flush with the same coefficients: smpl_out = 0x01FF (no saturation).
- Negative saturation and boundary:
  - samples 0x8000, coeff 0x7FFF: required 0x8000.
  - Single nonzero tap giving acc = 0x1FFFC00: required 0x7FFF unsaturated.
  - Single nonzero tap giving acc = 0x2000000: required 0x7FFF saturated.
  - Single nonzero tap giving acc = -0x2000000: required 0x8000 exact.
- Handshake: hold smpl_vld high continuously. Required: accepts exactly every NTAPS+1 cycles, smpl_rdy low throughout MAC, and no sample lost or duplicated when checked against a reference model.
- Flush mid-MAC at k = 5 with smpl_vld high in the same cycle. Required: no out_vld, sample dropped, smpl_rdy high next cycle, and the next impulse response matches a freshly reset filter.
- Async reset mid-MAC. Required: out_vld = 0, smpl_out = 0, coeff_addr = 0 immediately; normal operation resumes after rst_n is deasserted.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter blocks.
// Holds width defaults, the accumulator width derivation, the sequencer
// state type and the saturation constants.
package fir_pkg;

  localparam int unsigned NTAPS_DEF   = 16;
  localparam int unsigned DW_DEF      = 16;
  // Output is the accumulator scaled by 2^-SCALE_SHIFT.
  localparam int unsigned SCALE_SHIFT = 10;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [0:0] {StIdle, StMac} state_e;

  // Full product width plus growth for summing ntaps products: cannot overflow.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ntaps);
    return 2 * dw + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Sample/coefficient/result bundle of the FIR MAC sequencer.
//   flush      : synchronous clear of delay line and sequencer
//   smpl_in/smpl_vld/smpl_rdy : input sample handshake
//   coeff_addr/coeff : combinational coefficient ROM lookup
//   smpl_out/out_vld : filtered sample with one-cycle valid pulse
// slave is the filter's view, master the surrounding system's view.
interface fir_mac_seq_if
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned DW    = DW_DEF
);

  localparam int unsigned AW = $clog2(NTAPS);

  logic          flush;
  logic [DW-1:0] smpl_in;
  logic          smpl_vld;
  logic          smpl_rdy;
  logic [AW-1:0] coeff_addr;
  logic [DW-1:0] coeff;
  logic [DW-1:0] smpl_out;
  logic          out_vld;

  modport slave (
    input  flush, smpl_in, smpl_vld, coeff,
    output smpl_rdy, coeff_addr, smpl_out, out_vld
  );

  modport master (
    output flush, smpl_in, smpl_vld, coeff,
    input  smpl_rdy, coeff_addr, smpl_out, out_vld
  );

endinterface

// File: rtl/acc_sat.sv
// Combinational scale-by-2^-10 and saturate of a signed accumulator.
//   acc_i : signed accumulator, ACCW bits
//   res_o : signed DW-bit result, clamped to the DW-bit range
// The clamp decision looks at every bit above the result window, so any
// accumulator value outside the representable range saturates correctly.
module acc_sat
  import fir_pkg::*;
#(
  parameter int unsigned ACCW = 36,
  parameter int unsigned DW   = 16
) (
  input  logic [ACCW-1:0] acc_i,
  output logic [DW-1:0]   res_o
);

  localparam int unsigned Lo = SCALE_SHIFT;
  localparam int unsigned Hi = DW + SCALE_SHIFT - 1;

  logic [ACCW-1-Hi:0] top;
  logic               unused_lsb;

  assign top        = acc_i[ACCW-1:Hi];
  // Fractional bits are discarded by the scaling.
  assign unused_lsb = ^acc_i[Lo-1:0];

  always_comb begin
    if (&top || ~|top) begin
      res_o = acc_i[Hi:Lo];
    end else if (acc_i[ACCW-1]) begin
      res_o = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res_o = {1'b0, {(DW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// FIR sequencer around a single shared multiply-accumulate.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sample handshake, coefficient ROM port, filtered output
// Each accepted sample goes into a circular delay line; the next NTAPS cycles
// each add one sample*coefficient product (newest sample with coeff[0]), then
// the scaled, saturated sum is registered with a one-cycle out_vld.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input logic           clk,
  input logic           rst_n,
  fir_mac_seq_if.slave  bus
);

  localparam int unsigned AW   = $clog2(NTAPS);
  localparam int unsigned ACCW = acc_width(DW, NTAPS);

  state_e                 state_q, state_d;
  logic [DW-1:0]          dline_q [NTAPS];
  logic [DW-1:0]          dline_d [NTAPS];
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          tap_q, tap_d;
  logic [AW-1:0]          caddr_q, caddr_d;
  logic signed [ACCW-1:0] acc_q, acc_d, acc_nxt;
  logic [DW-1:0]          smpl_out_q, smpl_out_d;
  logic                   out_vld_q, out_vld_d;

  logic [AW-1:0]            rd_idx;
  logic signed [DW-1:0]     opd, cof;
  logic signed [2*DW-1:0]   prod;
  logic [DW-1:0]            sat_res;
  logic                     accept;

  // wptr points past the newest sample, so tap k reads wptr-1-k.
  assign rd_idx  = wptr_q - AW'(1) - tap_q;
  assign opd     = dline_q[rd_idx];
  assign cof     = bus.coeff;
  assign prod    = (2*DW)'(opd) * (2*DW)'(cof);
  assign acc_nxt = acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

  acc_sat #(
    .ACCW (ACCW),
    .DW   (DW)
  ) u_acc_sat (
    .acc_i (acc_nxt),
    .res_o (sat_res)
  );

  assign bus.smpl_rdy   = (state_q == StIdle) && !bus.flush;
  assign accept         = bus.smpl_vld && bus.smpl_rdy;
  // Live tap index while accumulating, last used index otherwise.
  assign bus.coeff_addr = (state_q == StMac) ? tap_q : caddr_q;
  assign bus.smpl_out   = smpl_out_q;
  assign bus.out_vld    = out_vld_q;

  always_comb begin
    state_d    = state_q;
    dline_d    = dline_q;
    wptr_d     = wptr_q;
    tap_d      = tap_q;
    caddr_d    = caddr_q;
    acc_d      = acc_q;
    smpl_out_d = smpl_out_q;
    out_vld_d  = 1'b0;
    if (bus.flush) begin
      for (int i = 0; i < NTAPS; i++) dline_d[i] = '0;
      wptr_d  = '0;
      tap_d   = '0;
      caddr_d = '0;
      acc_d   = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dline_d[wptr_q] = bus.smpl_in;
            wptr_d          = wptr_q + AW'(1);
            acc_d           = '0;
            tap_d           = '0;
            state_d         = StMac;
          end
        end
        StMac: begin
          acc_d   = acc_nxt;
          tap_d   = tap_q + AW'(1);
          caddr_d = tap_q;
          if (tap_q == AW'(NTAPS - 1)) begin
            smpl_out_d = sat_res;
            out_vld_d  = 1'b1;
            state_d    = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      for (int i = 0; i < NTAPS; i++) dline_q[i] <= '0;
      wptr_q     <= '0;
      tap_q      <= '0;
      caddr_q    <= '0;
      acc_q      <= '0;
      smpl_out_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dline_q    <= dline_d;
      wptr_q     <= wptr_d;
      tap_q      <= tap_d;
      caddr_q    <= caddr_d;
      acc_q      <= acc_d;
      smpl_out_q <= smpl_out_d;
      out_vld_q  <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: directed vector table plus sequences
// for impulse response, continuous handshake, flush and async reset.
module tb_fir_mac_seq;
  import fir_pkg::*;

  localparam int NT  = 16;
  localparam int LAT = NT + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] rom [NT];
  logic signed [15:0] mdl [NT];
  int mptr = 0;

  int n_chk  = 0;
  int n_pass = 0;

  fir_mac_seq_if #(.NTAPS(NT), .DW(16)) bus ();
  assign bus.coeff = rom[bus.coeff_addr];

  fir_mac_seq #(.NTAPS(NT), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] smpl;
    logic [15:0] c0;
    logic [15:0] crest;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: exact sum, arithmetic shift, clamp to 16-bit range.
  function automatic logic [15:0] model_out();
    longint acc = 0;
    longint s;
    for (int k = 0; k < NT; k++)
      acc += longint'(mdl[(mptr - 1 - k + NT) % NT]) * longint'(rom[k]);
    s = acc >>> 10;
    if (s > 32767) return SAT_POS;
    if (s < -32768) return SAT_NEG;
    return 16'(s);
  endfunction

  task automatic do_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    mptr = 0;
    for (int i = 0; i < NT; i++) mdl[i] = '0;
    #1;
  endtask

  task automatic send(input logic [15:0] s, output int t);
    int n = 0;
    bus.smpl_in  = s;
    bus.smpl_vld = 1'b1;
    while (!bus.smpl_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_rdy", longint'(bus.smpl_rdy), 1);
    t = cyc;
    @(negedge clk);
    bus.smpl_vld = 1'b0;
  endtask

  task automatic wait_out(output logic [15:0] v, output int t);
    int n = 0;
    while (!bus.out_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_vld_seen", longint'(bus.out_vld), 1);
    v = bus.smpl_out;
    t = cyc;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NT; k++) rom[k] = 16'(100 + k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int t_a, t_o, cnt;
    logic [15:0] held;

    vecs[0] = '{16'h0400, 16'd100,  16'h0000, 16'h0064};
    vecs[1] = '{16'h0400, 16'h7FFF, 16'h0000, 16'h7FFF};  // acc 0x1FFFC00
    vecs[2] = '{16'h8000, 16'hFC00, 16'h0000, SAT_POS};   // acc 0x2000000
    vecs[3] = '{16'h8000, 16'h0400, 16'h0000, SAT_NEG};   // acc -0x2000000
    vecs[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, SAT_POS};
    vecs[5] = '{16'h0010, 16'h7FFF, 16'h7FFF, 16'h01FF};
    vecs[6] = '{16'h8000, 16'h7FFF, 16'h7FFF, SAT_NEG};
    vecs[7] = '{16'hFC00, 16'd100,  16'h0000, 16'hFF9C};
    vecs[8] = '{16'h0001, 16'h0400, 16'h0000, 16'h0001};
    vecs[9] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF};

    bus.flush    = 1'b0;
    bus.smpl_vld = 1'b0;
    bus.smpl_in  = '0;
    for (int k = 0; k < NT; k++) begin
      rom[k] = '0;
      mdl[k] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_vld", longint'(bus.out_vld), 0);
    chk("rst_smpl_out", longint'(bus.smpl_out), 0);
    chk("rst_coeff_addr", longint'(bus.coeff_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", longint'(bus.smpl_rdy), 1);

    // Impulse response, back-to-back samples
    set_ramp();
    for (int i = 0; i < NT; i++) begin
      send((i == 0) ? 16'h0400 : 16'h0000, t_a);
      wait_out(v, t_o);
      chk($sformatf("impulse%0d_val", i), longint'(v), 100 + i);
      chk($sformatf("impulse%0d_lat", i), t_o - t_a, LAT);
    end

    // Vector table: one sample into a freshly flushed line
    for (int i = 0; i < 10; i++) begin
      do_flush();
      rom[0] = vecs[i].c0;
      for (int k = 1; k < NT; k++) rom[k] = vecs[i].crest;
      send(vecs[i].smpl, t_a);
      wait_out(v, t_o);
      chk($sformatf("vec%0d_val", i), longint'(v), longint'(vecs[i].exp));
      chk($sformatf("vec%0d_lat", i), t_o - t_a, LAT);
    end

    // Continuous smpl_vld against the reference model
    begin
      int n_acc = 0, n_out = 0, last_t = -1, low_cnt = 0, guard = 0;
      logic [15:0] expq[$];
      int tq[$];
      logic acc_now;
      do_flush();
      for (int k = 0; k < NT; k++) rom[k] = 16'(k * 2311 - 17000);
      bus.smpl_in  = 16'h1234;
      bus.smpl_vld = 1'b1;
      while (n_out < 20 && guard < 1000) begin
        if (bus.out_vld) begin
          if (expq.size() == 0) begin
            chk("hs_spurious_out", expq.size(), 1);
          end else begin
            chk("hs_val", longint'(bus.smpl_out), longint'(expq.pop_front()));
            chk("hs_lat", cyc - tq.pop_front(), LAT);
          end
          n_out++;
        end
        if (n_acc == 20) bus.smpl_vld = 1'b0;
        acc_now = bus.smpl_vld && bus.smpl_rdy;
        if (acc_now) begin
          if (last_t >= 0) begin
            chk("hs_interval", cyc - last_t, LAT);
            chk("hs_rdy_low", low_cnt, NT);
          end
          last_t  = cyc;
          low_cnt = 0;
          mdl[mptr] = bus.smpl_in;
          mptr = (mptr + 1) % NT;
          expq.push_back(model_out());
          tq.push_back(cyc);
          n_acc++;
        end else if (!bus.smpl_rdy) begin
          low_cnt++;
        end
        @(negedge clk);
        guard++;
        if (acc_now) bus.smpl_in = 16'(n_acc * 4973 + 16'h0321);
      end
      bus.smpl_vld = 1'b0;
      chk("hs_outputs", n_out, 20);
      chk("hs_accepts", n_acc, 20);
    end

    // Flush at k=5 with a sample offered in the same cycle
    do_flush();
    set_ramp();
    send(16'h1000, t_a);
    wait_out(v, t_o);
    chk("pre_flush_val", longint'(v), 16'h0190);
    send(16'h1000, t_a);
    repeat (5) @(negedge clk);
    chk("flush_k", longint'(bus.coeff_addr), 5);
    held = bus.smpl_out;
    bus.flush    = 1'b1;
    bus.smpl_vld = 1'b1;
    bus.smpl_in  = 16'h2222;
    #1;
    chk("flush_rdy_low", longint'(bus.smpl_rdy), 0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.smpl_vld = 1'b0;
    #1;
    chk("flush_rdy_next", longint'(bus.smpl_rdy), 1);
    chk("flush_caddr", longint'(bus.coeff_addr), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_vld) cnt++;
    end
    chk("flush_no_vld", cnt, 0);
    chk("flush_hold_out", longint'(bus.smpl_out), longint'(held));
    send(16'h0400, t_a);
    wait_out(v, t_o);
    chk("post_flush_val0", longint'(v), 100);
    chk("post_flush_lat0", t_o - t_a, LAT);
    send(16'h0000, t_a);
    wait_out(v, t_o);
    chk("post_flush_val1", longint'(v), 101);

    // Asynchronous reset in the middle of a computation
    send(16'h0400, t_a);
    repeat (3) @(negedge clk);
    chk("pre_rst_caddr", longint'(bus.coeff_addr), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_vld", longint'(bus.out_vld), 0);
    chk("arst_smpl_out", longint'(bus.smpl_out), 0);
    chk("arst_caddr", longint'(bus.coeff_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rdy", longint'(bus.smpl_rdy), 1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_vld) cnt++;
    end
    chk("arst_no_vld", cnt, 0);
    send(16'h0400, t_a);
    wait_out(v, t_o);
    chk("post_rst_val0", longint'(v), 100);
    chk("post_rst_lat0", t_o - t_a, LAT);
    send(16'h0000, t_a);
    wait_out(v, t_o);
    chk("post_rst_val1", longint'(v), 101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
